// File: rtl/bp_lce_req_gen_if.sv
// Cache-side request bus and LCE-side request/response buses of bp_lce_req_gen.
// The master modport is the request generator; slave is its environment.
interface bp_lce_req_gen_if #(
    parameter int paddr_width_p  = 40,
    parameter int cce_id_width_p = 2,
    parameter int way_width_p    = 3
);
    logic                      cache_req_v_i;
    logic                      cache_req_ready_o;
    logic [1:0]                cache_req_type_i;
    logic [paddr_width_p-1:0]  cache_req_addr_i;
    logic [1:0]                cache_req_size_i;
    logic [63:0]               cache_req_data_i;
    logic                      cache_req_metadata_v_i;
    logic [way_width_p-1:0]    cache_req_way_i;
    logic                      cache_req_dirty_i;

    logic                      lce_req_v_o;
    logic                      lce_req_ready_i;
    logic [1:0]                lce_req_type_o;
    logic [paddr_width_p-1:0]  lce_req_addr_o;
    logic [way_width_p-1:0]    lce_req_way_o;
    logic                      lce_req_dirty_o;
    logic [1:0]                lce_req_size_o;
    logic [63:0]               lce_req_data_o;
    logic [cce_id_width_p-1:0] dst_id_o;
    logic                      lce_resp_v_o;
    logic                      lce_resp_yumi_i;

    modport master (
        input  cache_req_v_i, cache_req_type_i, cache_req_addr_i, cache_req_size_i,
               cache_req_data_i, cache_req_metadata_v_i, cache_req_way_i, cache_req_dirty_i,
               lce_req_ready_i, lce_resp_yumi_i,
        output cache_req_ready_o,
               lce_req_v_o, lce_req_type_o, lce_req_addr_o, lce_req_way_o, lce_req_dirty_o,
               lce_req_size_o, lce_req_data_o, dst_id_o, lce_resp_v_o
    );

    modport slave (
        output cache_req_v_i, cache_req_type_i, cache_req_addr_i, cache_req_size_i,
               cache_req_data_i, cache_req_metadata_v_i, cache_req_way_i, cache_req_dirty_i,
               lce_req_ready_i, lce_resp_yumi_i,
        input  cache_req_ready_o,
               lce_req_v_o, lce_req_type_o, lce_req_addr_o, lce_req_way_o, lce_req_dirty_o,
               lce_req_size_o, lce_req_data_o, dst_id_o, lce_resp_v_o
    );
endinterface

// File: rtl/bp_lce_req_gen.sv
// LCE request generator: turns cache miss/uncached requests into LCE requests and coh_acks.
// Optional SLEEP watchdog enabled by defining BP_LCE_REQ_WATCHDOG_EN.
module bp_lce_req_gen #(
    parameter int paddr_width_p       = 40,
    parameter int cce_id_width_p      = 2,
    parameter int assoc_p             = 8,
    parameter int timeout_max_limit_p = 4,
    parameter int sleep_timeout_p     = 1024,
    localparam int way_width_lp       = (assoc_p > 1) ? $clog2(assoc_p) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [3:0]             lce_id_i,
    input  logic                   coherence_blocked_i,
    input  logic                   cmd_ready_i,
    input  logic                   data_received_i,
    input  logic                   set_tag_received_i,
    input  logic                   set_tag_wakeup_received_i,
    input  logic                   uc_data_received_i,
    output logic                   err_o,
    bp_lce_req_gen_if.master       bus
);

    localparam int cnt_width_lp = $clog2(timeout_max_limit_p + 1);

    typedef enum logic [1:0] {
        READY = 2'd0,
        SEND  = 2'd1,
        SLEEP = 2'd2,
        ACK   = 2'd3
    } state_e;

    state_e                    r_state;
    state_e                    w_next_state;
    logic [1:0]                r_type;
    logic [paddr_width_p-1:0]  r_addr;
    logic [1:0]                r_size;
    logic [63:0]               r_data;
    logic [way_width_lp-1:0]   r_way;
    logic                      r_dirty;
    logic                      r_meta_v;
    logic                      r_tag_flag;
    logic                      r_data_flag;
    logic [cnt_width_lp-1:0]   r_blk_cnt;

    logic                      w_timeout;
    logic                      w_ready;
    logic                      w_accept;
    logic                      w_is_uc;
    logic                      w_req_v;
    logic                      w_send_done;
    logic                      w_tag_seen;
    logic                      w_data_seen;
    logic                      w_err;
    logic [paddr_width_p-1:0]  w_addr_mask;
    logic [paddr_width_p-1:0]  w_req_addr;
    logic [paddr_width_p-1:0]  w_addr_out;
    logic                      w_unused;

    assign w_unused    = ^{lce_id_i, 32'(sleep_timeout_p)};

    assign w_timeout   = (r_blk_cnt == cnt_width_lp'(timeout_max_limit_p));
    assign w_ready     = (r_state == READY) & cmd_ready_i & ~w_timeout;
    assign w_accept    = bus.cache_req_v_i & w_ready;
    assign w_is_uc     = r_type[1];
    assign w_req_v     = (r_state == SEND) & (w_is_uc | r_meta_v);
    assign w_send_done = w_req_v & bus.lce_req_ready_i;
    assign w_tag_seen  = r_tag_flag | set_tag_received_i;
    assign w_data_seen = r_data_flag | data_received_i;

    // Uncached requests are aligned to their own size; misses carry the full address.
    assign w_addr_mask = ~((paddr_width_p'(1) << r_size) - paddr_width_p'(1));
    assign w_req_addr  = w_is_uc ? (r_addr & w_addr_mask) : r_addr;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_blk_cnt <= '0;
        end else if (!coherence_blocked_i) begin
            r_blk_cnt <= '0;
        end else if (!w_timeout) begin
            r_blk_cnt <= r_blk_cnt + cnt_width_lp'(1);
        end
    end

`ifdef BP_LCE_REQ_WATCHDOG_EN
    localparam int sleep_width_lp = $clog2(sleep_timeout_p + 1);

    logic [sleep_width_lp-1:0] r_sleep_cnt;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i || (r_state != SLEEP)) begin
            r_sleep_cnt <= '0;
        end else begin
            r_sleep_cnt <= r_sleep_cnt + sleep_width_lp'(1);
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= READY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_err        = 1'b0;
        case (r_state)
            READY: begin
                if (w_accept) begin
                    w_next_state = SEND;
                end
            end
            SEND: begin
                if (w_send_done) begin
                    w_next_state = (r_type == 2'd3) ? READY : SLEEP;
                end
            end
            SLEEP: begin
                if (set_tag_wakeup_received_i) begin
                    w_next_state = ACK;
                end else if (r_type == 2'd2) begin
                    if (uc_data_received_i) begin
                        w_next_state = READY;
                    end
                end else if (w_tag_seen && w_data_seen) begin
                    w_next_state = ACK;
                end
`ifdef BP_LCE_REQ_WATCHDOG_EN
                // Watchdog fires only when no legitimate exit happens this cycle.
                if ((w_next_state == SLEEP) &&
                    (r_sleep_cnt == sleep_width_lp'(sleep_timeout_p - 1))) begin
                    w_err        = 1'b1;
                    w_next_state = READY;
                end
`endif
            end
            ACK: begin
                if (bus.lce_resp_yumi_i) begin
                    w_next_state = READY;
                end
            end
            default: begin
                w_next_state = READY;
            end
        endcase
    end

    // Request latches; metadata is captured once, the earliest valid beat wins.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_type      <= '0;
            r_addr      <= '0;
            r_size      <= '0;
            r_data      <= '0;
            r_way       <= '0;
            r_dirty     <= 1'b0;
            r_meta_v    <= 1'b0;
            r_tag_flag  <= 1'b0;
            r_data_flag <= 1'b0;
        end else if (w_accept) begin
            r_type      <= bus.cache_req_type_i;
            r_addr      <= bus.cache_req_addr_i;
            r_size      <= bus.cache_req_size_i;
            r_data      <= bus.cache_req_data_i;
            r_meta_v    <= bus.cache_req_metadata_v_i;
            r_tag_flag  <= 1'b0;
            r_data_flag <= 1'b0;
            if (bus.cache_req_metadata_v_i) begin
                r_way   <= bus.cache_req_way_i;
                r_dirty <= bus.cache_req_dirty_i;
            end
        end else if (r_state == SEND) begin
            if (bus.cache_req_metadata_v_i && !r_meta_v) begin
                r_way    <= bus.cache_req_way_i;
                r_dirty  <= bus.cache_req_dirty_i;
                r_meta_v <= 1'b1;
            end
        end else if (r_state == SLEEP) begin
            if (set_tag_received_i) begin
                r_tag_flag <= 1'b1;
            end
            if (data_received_i) begin
                r_data_flag <= 1'b1;
            end
        end
    end

    // Every output is forced low while reset is asserted.
    assign w_addr_out            = reset_n_i ? w_req_addr : '0;
    assign bus.cache_req_ready_o = reset_n_i & w_ready;
    assign bus.lce_req_v_o       = reset_n_i & w_req_v;
    assign bus.lce_req_type_o    = reset_n_i ? r_type  : 2'd0;
    assign bus.lce_req_addr_o    = w_addr_out;
    assign bus.lce_req_way_o     = reset_n_i ? r_way   : '0;
    assign bus.lce_req_dirty_o   = reset_n_i & r_dirty;
    assign bus.lce_req_size_o    = reset_n_i ? r_size  : 2'd0;
    assign bus.lce_req_data_o    = reset_n_i ? r_data  : 64'd0;
    assign bus.dst_id_o          = w_addr_out[6 +: cce_id_width_p];
    assign bus.lce_resp_v_o      = reset_n_i & (r_state == ACK);
    assign err_o                 = reset_n_i & w_err;

endmodule

// File: tb/tb_bp_lce_req_gen.sv
// Self-checking bench for bp_lce_req_gen: transaction-level model, directed cases, random traffic.
// Watchdog expectations are included when BP_LCE_REQ_WATCHDOG_EN is defined.
module tb_bp_lce_req_gen;

    localparam int PW  = 40;
    localparam int CW  = 2;
    localparam int WW  = 3;
    localparam int LIM = 4;
    localparam int SLP = 1024;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] lceId;
    logic       blocked, cmdReady, dataRx, tagRx, wakeRx, ucDataRx;
    logic       err;

    int passCount  = 0;
    int totalCount = 0;

    bp_lce_req_gen_if #(.paddr_width_p(PW), .cce_id_width_p(CW), .way_width_p(WW)) bus ();

    bp_lce_req_gen #(
        .paddr_width_p(PW), .cce_id_width_p(CW), .assoc_p(8),
        .timeout_max_limit_p(LIM), .sleep_timeout_p(SLP)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .lce_id_i(lceId),
        .coherence_blocked_i(blocked), .cmd_ready_i(cmdReady),
        .data_received_i(dataRx), .set_tag_received_i(tagRx),
        .set_tag_wakeup_received_i(wakeRx), .uc_data_received_i(ucDataRx),
        .err_o(err), .bus(bus)
    );

    always #5 clk = ~clk;

    // Outstanding-transaction model: one request at a time, described by progress flags.
    bit          mBusy, mSent, mAck, mHaveMeta, mGotTag, mGotData, mDirty;
    logic [1:0]  mType, mSize;
    logic [39:0] mAddr;
    logic [63:0] mData;
    logic [2:0]  mWay;
    int          mBlk, mSleepCycles;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            passCount++;
        end
    endtask

    function automatic logic [39:0] expAddr();
        longint unsigned a, g;
        a = 64'(mAddr);
        g = 64'd1 << mSize;
        if (mType >= 2'd2) return 40'(a - (a % g));
        return mAddr;
    endfunction

    function automatic bit expReady();
        return !mBusy && cmdReady && (mBlk < LIM);
    endfunction

    function automatic bit expReqV();
        return mBusy && !mSent && !mAck && (mType >= 2'd2 || mHaveMeta);
    endfunction

    function automatic bit sleeping();
        return mBusy && mSent && !mAck;
    endfunction

    function automatic bit sleepExit();
        if (wakeRx) return 1'b1;
        if (mType == 2'd2) return ucDataRx;
        return (mGotTag || tagRx) && (mGotData || dataRx);
    endfunction

    function automatic bit expErr();
`ifdef BP_LCE_REQ_WATCHDOG_EN
        return sleeping() && !sleepExit() && (mSleepCycles == SLP - 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput();
        logic [39:0] ea;
        ea = expAddr();
        if (!reset_n) begin
            check("rst ready", 64'(bus.cache_req_ready_o), 64'd0);
            check("rst req_v", 64'(bus.lce_req_v_o), 64'd0);
            check("rst resp_v", 64'(bus.lce_resp_v_o), 64'd0);
            check("rst err", 64'(err), 64'd0);
            check("rst addr", 64'(bus.lce_req_addr_o), 64'd0);
            check("rst data", bus.lce_req_data_o, 64'd0);
            check("rst type", 64'(bus.lce_req_type_o), 64'd0);
            check("rst way", 64'(bus.lce_req_way_o), 64'd0);
            check("rst dst", 64'(bus.dst_id_o), 64'd0);
        end else begin
            check("ready", 64'(bus.cache_req_ready_o), 64'(expReady()));
            check("req_v", 64'(bus.lce_req_v_o), 64'(expReqV()));
            check("resp_v", 64'(bus.lce_resp_v_o), 64'(mAck));
            check("err", 64'(err), 64'(expErr()));
            if (expReqV()) begin
                check("req type", 64'(bus.lce_req_type_o), 64'(mType));
                check("req addr", 64'(bus.lce_req_addr_o), 64'(ea));
                check("req size", 64'(bus.lce_req_size_o), 64'(mSize));
                check("req data", bus.lce_req_data_o, mData);
                check("req dst", 64'(bus.dst_id_o), 64'(ea[6 +: CW]));
                if (mType < 2'd2) begin
                    check("req way", 64'(bus.lce_req_way_o), 64'(mWay));
                    check("req dirty", 64'(bus.lce_req_dirty_o), 64'(mDirty));
                end
            end
            if (mAck) begin
                check("resp dst", 64'(bus.dst_id_o), 64'(ea[6 +: CW]));
            end
        end
    endtask

    task automatic modelStep();
        bit rdy, rv;
        if (!reset_n) begin
            mBusy = 0; mSent = 0; mAck = 0; mHaveMeta = 0; mGotTag = 0; mGotData = 0;
            mType = 0; mSize = 0; mAddr = 0; mData = 0; mWay = 0; mDirty = 0;
            mBlk = 0; mSleepCycles = 0;
            return;
        end
        rdy  = expReady();
        rv   = expReqV();
        mBlk = blocked ? ((mBlk < LIM) ? mBlk + 1 : LIM) : 0;
        if (!mBusy) begin
            if (bus.cache_req_v_i && rdy) begin
                mBusy = 1; mSent = 0; mAck = 0; mGotTag = 0; mGotData = 0;
                mType = bus.cache_req_type_i; mAddr = bus.cache_req_addr_i;
                mSize = bus.cache_req_size_i; mData = bus.cache_req_data_i;
                mHaveMeta = bus.cache_req_metadata_v_i;
                if (mHaveMeta) begin
                    mWay = bus.cache_req_way_i; mDirty = bus.cache_req_dirty_i;
                end
            end
        end else if (!mSent) begin
            if (bus.cache_req_metadata_v_i && !mHaveMeta) begin
                mHaveMeta = 1; mWay = bus.cache_req_way_i; mDirty = bus.cache_req_dirty_i;
            end
            if (rv && bus.lce_req_ready_i) begin
                if (mType == 2'd3) mBusy = 0;
                else begin mSent = 1; mSleepCycles = 0; end
            end
        end else if (!mAck) begin
            if (wakeRx) mAck = 1;
            else if (mType == 2'd2) begin
                if (ucDataRx) begin mBusy = 0; mSent = 0; end
            end else if ((mGotTag || tagRx) && (mGotData || dataRx)) mAck = 1;
            if (!sleepExit()) begin
                mGotTag  = mGotTag  | tagRx;
                mGotData = mGotData | dataRx;
`ifdef BP_LCE_REQ_WATCHDOG_EN
                if (mSleepCycles == SLP - 1) begin mBusy = 0; mSent = 0; end
`endif
                mSleepCycles++;
            end
        end else if (bus.lce_resp_yumi_i) begin
            mBusy = 0; mSent = 0; mAck = 0;
        end
    endtask

    task automatic tick();
        #1;
        checkOutput();
        modelStep();
        @(negedge clk);
    endtask

    task automatic setIdle();
        reset_n = 1'b1; lceId = 4'h3; blocked = 0; cmdReady = 1;
        dataRx = 0; tagRx = 0; wakeRx = 0; ucDataRx = 0;
        bus.cache_req_v_i = 0; bus.cache_req_type_i = 0; bus.cache_req_addr_i = '0;
        bus.cache_req_size_i = 0; bus.cache_req_data_i = '0; bus.cache_req_metadata_v_i = 0;
        bus.cache_req_way_i = 0; bus.cache_req_dirty_i = 0;
        bus.lce_req_ready_i = 0; bus.lce_resp_yumi_i = 0;
    endtask

    int burst = 0;

    task automatic applyStimulus();
        reset_n = ($urandom_range(0, 299) != 0);
        lceId = 4'($urandom);
        bus.cache_req_v_i = $urandom_range(0, 1) == 1;
        bus.cache_req_type_i = 2'($urandom_range(0, 3));
        bus.cache_req_addr_i = 40'({$urandom(), $urandom()});
        bus.cache_req_size_i = 2'($urandom_range(0, 3));
        bus.cache_req_data_i = {$urandom(), $urandom()};
        bus.cache_req_metadata_v_i = $urandom_range(0, 3) == 0;
        bus.cache_req_way_i = 3'($urandom);
        bus.cache_req_dirty_i = 1'($urandom);
        if (burst == 0 && $urandom_range(0, 29) == 0) burst = $urandom_range(1, 7);
        blocked = (burst != 0);
        if (burst != 0) burst--;
        cmdReady = $urandom_range(0, 7) != 0;
        bus.lce_req_ready_i = $urandom_range(0, 1) == 1;
        dataRx = $urandom_range(0, 5) == 0;
        tagRx = $urandom_range(0, 5) == 0;
        wakeRx = $urandom_range(0, 39) == 0;
        ucDataRx = $urandom_range(0, 3) == 0;
        bus.lce_resp_yumi_i = $urandom_range(0, 1) == 1;
    endtask

    initial begin
        setIdle();
        reset_n = 1'b0;
        @(negedge clk);
        #1 check("reset ready literal", 64'(bus.cache_req_ready_o), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        #1 check("post-reset ready literal", 64'(bus.cache_req_ready_o), 64'd1);
        tick();

        // Miss load, metadata three cycles after accept, tag then data.
        setIdle();
        bus.cache_req_v_i = 1; bus.cache_req_type_i = 2'd0; bus.cache_req_addr_i = 40'h80001234;
        bus.lce_req_ready_i = 1;
        tick();
        bus.cache_req_v_i = 0;
        repeat (2) begin
            #1 check("miss waits for meta", 64'(bus.lce_req_v_o), 64'd0);
            tick();
        end
        bus.cache_req_metadata_v_i = 1; bus.cache_req_way_i = 3'd5;
        #1 check("miss meta cycle", 64'(bus.lce_req_v_o), 64'd0);
        tick();
        bus.cache_req_metadata_v_i = 0;
        #1;
        check("miss v literal", 64'(bus.lce_req_v_o), 64'd1);
        check("miss type literal", 64'(bus.lce_req_type_o), 64'd0);
        check("miss addr literal", 64'(bus.lce_req_addr_o), 64'h80001234);
        check("miss way literal", 64'(bus.lce_req_way_o), 64'd5);
        tick();
        tagRx = 1;
        tick();
        tagRx = 0; dataRx = 1;
        #1 check("miss no early ack", 64'(bus.lce_resp_v_o), 64'd0);
        tick();
        dataRx = 0;
        #1 check("miss ack literal", 64'(bus.lce_resp_v_o), 64'd1);
        bus.lce_resp_yumi_i = 1;
        tick();
        bus.lce_resp_yumi_i = 0;
        #1 check("miss single ack", 64'(bus.lce_resp_v_o), 64'd0);
        tick();

        // Uncached load, 8-byte aligned.
        bus.cache_req_v_i = 1; bus.cache_req_type_i = 2'd2;
        bus.cache_req_addr_i = 40'h80000007; bus.cache_req_size_i = 2'd3;
        tick();
        bus.cache_req_v_i = 0;
        #1;
        check("uc_ld addr literal", 64'(bus.lce_req_addr_o), 64'h80000000);
        check("uc_ld type literal", 64'(bus.lce_req_type_o), 64'd2);
        tick();
        ucDataRx = 1;
        tick();
        ucDataRx = 0;
        #1;
        check("uc_ld back to ready", 64'(bus.cache_req_ready_o), 64'd1);
        check("uc_ld no ack", 64'(bus.lce_resp_v_o), 64'd0);
        tick();

        // Posted uncached store.
        bus.cache_req_v_i = 1; bus.cache_req_type_i = 2'd3; bus.cache_req_addr_i = 40'h1006;
        bus.cache_req_size_i = 2'd1; bus.cache_req_data_i = 64'hAB;
        tick();
        bus.cache_req_v_i = 0;
        #1;
        check("uc_st addr literal", 64'(bus.lce_req_addr_o), 64'h1006);
        check("uc_st type literal", 64'(bus.lce_req_type_o), 64'd3);
        check("uc_st data literal", bus.lce_req_data_o, 64'hAB);
        tick();
        #1 check("uc_st ready next", 64'(bus.cache_req_ready_o), 64'd1);
        tick();

        // Blocked-cycle timeout.
        blocked = 1;
        for (int i = 0; i < 4; i++) begin
            #1 check("blocked ready held", 64'(bus.cache_req_ready_o), 64'd1);
            tick();
        end
        #1 check("blocked ready dropped", 64'(bus.cache_req_ready_o), 64'd0);
        tick();
        blocked = 0;
        #1 check("blocked still saturated", 64'(bus.cache_req_ready_o), 64'd0);
        tick();
        #1 check("blocked ready returns", 64'(bus.cache_req_ready_o), 64'd1);
        tick();

        // Tag and data together, yumi delayed three cycles.
        bus.cache_req_v_i = 1; bus.cache_req_type_i = 2'd1; bus.cache_req_addr_i = 40'h12345678C0;
        bus.cache_req_metadata_v_i = 1; bus.cache_req_way_i = 3'd2; bus.cache_req_dirty_i = 1;
        tick();
        bus.cache_req_v_i = 0; bus.cache_req_metadata_v_i = 0;
        #1 check("store dirty literal", 64'(bus.lce_req_dirty_o), 64'd1);
        tick();
        tagRx = 1; dataRx = 1;
        tick();
        tagRx = 0; dataRx = 0;
        repeat (3) begin
            #1 check("ack held literal", 64'(bus.lce_resp_v_o), 64'd1);
            tick();
        end
        bus.lce_resp_yumi_i = 1;
        #1 check("ack 4th cycle", 64'(bus.lce_resp_v_o), 64'd1);
        tick();
        bus.lce_resp_yumi_i = 0;
        #1 check("ack released", 64'(bus.lce_resp_v_o), 64'd0);
        tick();

        // Reset while a request sits in SEND.
        bus.cache_req_v_i = 1; bus.cache_req_type_i = 2'd0; bus.cache_req_addr_i = 40'h4000;
        tick();
        bus.cache_req_v_i = 0;
        tick();
        reset_n = 0;
        tick();
        reset_n = 1; bus.cache_req_metadata_v_i = 1;
        #1;
        check("dropped req_v", 64'(bus.lce_req_v_o), 64'd0);
        check("dropped ready", 64'(bus.cache_req_ready_o), 64'd1);
        tick();
        bus.cache_req_metadata_v_i = 0;

`ifdef BP_LCE_REQ_WATCHDOG_EN
        begin
            int n;
            bit seen;
            setIdle();
            bus.cache_req_v_i = 1; bus.cache_req_type_i = 2'd0; bus.cache_req_metadata_v_i = 1;
            bus.lce_req_ready_i = 1;
            tick();
            bus.cache_req_v_i = 0; bus.cache_req_metadata_v_i = 0;
            tick();
            n = 0;
            seen = 0;
            while (!seen && n < 2000) begin
                #1;
                n++;
                if (err) seen = 1;
                tick();
            end
            check("watchdog cycle", 64'(n), 64'(SLP));
        end
`endif

        repeat (4000) begin
            applyStimulus();
            tick();
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
